matvec_int8_lanes: RTL and testbench

Parametrised successor to the single-lane int8 matrix-vector engine. Computes out = requant(W · x) for an OUT_DIM×IN_DIM int8 matrix held in external synchronous BRAM, producing LANES output rows per pass from one wide weight word. Adds a runtime requantisation shift with round-half-up and saturation. Sits between the block weight ROMs and the attention/MLP datapath.

---
 rtl/matvec_int8_lanes.sv | 159 +++++++++++++++
 tb/tb_matvec_int8_lanes.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_int8_lanes.sv
// matvec_int8_lanes: int8 matrix-vector engine computing LANES output rows per
// pass from one wide weight word, with runtime round-half-up requant shift and
// saturation to int8.
// Optional build macro MATVEC_LANES_RELU_EN: negative results are written as 0.
module matvec_int8_lanes #(
    parameter int IN_DIM  = 128,
    parameter int OUT_DIM = 128,
    parameter int LANES   = 4,
    parameter int ACC_W   = 24,
    parameter int ADDR_W  = $clog2((OUT_DIM / LANES) * IN_DIM)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [4:0]            shift_i,
    input  logic [8*IN_DIM-1:0]   in_vec_i,
    output logic                  weight_en_o,
    output logic [ADDR_W-1:0]     weight_addr_o,
    input  logic [8*LANES-1:0]    weight_data_i,
    output logic [8*OUT_DIM-1:0]  out_vec_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int GROUPS = OUT_DIM / LANES;
    localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int COL_W  = $clog2(IN_DIM);
    // Requant math is done wide enough that a 31-bit shift and its rounding
    // constant never truncate.
    localparam int RQ_W   = ACC_W + 33;
    localparam logic signed [RQ_W-1:0] SAT_HI = RQ_W'(127);
    localparam logic signed [RQ_W-1:0] SAT_LO = RQ_W'(-128);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [GRP_W-1:0]     grp;
    logic [COL_W-1:0]     col;
    logic [ADDR_W-1:0]    addr;
    logic                 pend_valid;
    logic [COL_W-1:0]     pend_col;
    logic [8*IN_DIM-1:0]  x_lat;
    logic [4:0]           shift_lat;
    logic signed [7:0]    x_cur;
    logic [8*LANES-1:0]   lane_y;
    logic                 accept;
    logic                 last_col;
    logic                 last_grp;

    assign accept   = (state == IDLE) && start_i;
    assign last_col = (col == COL_W'(IN_DIM - 1));
    assign last_grp = (grp == GRP_W'(GROUPS - 1));

    assign weight_en_o   = (state == FETCH);
    assign weight_addr_o = (state == FETCH) ? addr : '0;
    assign busy_o        = (state == FETCH) || (state == DRAIN) || (state == WRITE);
    assign done_o        = (state == DONE);

    // Input element matching the weight word currently on weight_data_i.
    assign x_cur = $signed(x_lat[8*pend_col +: 8]);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = FETCH;
            FETCH:   if (last_col) state_next = DRAIN;
            DRAIN:   state_next = WRITE;
            WRITE:   state_next = last_grp ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Group/column/address counters, input latch and read-data pipeline tag.
    // The address counter runs linearly since g*IN_DIM+c is sequential.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grp        <= '0;
            col        <= '0;
            addr       <= '0;
            pend_valid <= 1'b0;
            pend_col   <= '0;
            x_lat      <= '0;
            shift_lat  <= '0;
        end else begin
            pend_valid <= (state == FETCH);
            pend_col   <= col;
            case (state)
                IDLE: if (start_i) begin
                    x_lat     <= in_vec_i;
                    shift_lat <= shift_i;
                    grp       <= '0;
                    col       <= '0;
                    addr      <= '0;
                end
                FETCH: begin
                    addr <= addr + 1'b1;
                    col  <= last_col ? '0 : col + 1'b1;
                end
                WRITE: if (!last_grp) grp <= grp + 1'b1;
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [ACC_W-1:0] acc;
        logic signed [15:0]      w_ext;
        logic signed [15:0]      x_ext;
        logic signed [15:0]      prod;
        logic signed [RQ_W-1:0]  rnd;
        logic signed [RQ_W-1:0]  rq_sum;
        logic signed [RQ_W-1:0]  rq_shift;
        logic signed [7:0]       y;

        assign w_ext    = 16'($signed(weight_data_i[8*gi +: 8]));
        assign x_ext    = 16'(x_cur);
        assign prod     = w_ext * x_ext;
        assign rnd      = (shift_lat == 5'd0) ? '0 : RQ_W'(1) << (shift_lat - 5'd1);
        assign rq_sum   = {{(RQ_W-ACC_W){acc[ACC_W-1]}}, acc} + rnd;
        assign rq_shift = rq_sum >>> shift_lat;

        // Per-lane accumulator: cleared at start and after each row write.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)                         acc <= '0;
            else if (accept || state == WRITE) acc <= '0;
            else if (pend_valid)               acc <= acc + {{(ACC_W-16){prod[15]}}, prod};
        end

        // Saturate the rounded value to int8 (and clamp negatives when ReLU is built in).
        always_comb begin
            y = rq_shift[7:0];
            if (rq_shift > SAT_HI)      y = 8'sd127;
            else if (rq_shift < SAT_LO) y = -8'sd128;
`ifdef MATVEC_LANES_RELU_EN
            if (y < 0) y = 8'sd0;
`endif
        end

        assign lane_y[8*gi +: 8] = y;
    end

    // Result rows of the current group are written in the WRITE cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_vec_o <= '0;
        end else if (state == WRITE) begin
            for (int l = 0; l < LANES; l++)
                out_vec_o[8*(int'(grp)*LANES + l) +: 8] <= lane_y[8*l +: 8];
        end
    end
endmodule

// File: tb/tb_matvec_int8_lanes.sv
// Bench for matvec_int8_lanes: randomized and directed passes against an
// arithmetic reference model, plus latency, address-sweep and control corners.
// Edge numbering: the edge that accepts start is edge 1.
module tb_matvec_int8_lanes;
    localparam int IN_DIM  = 128;
    localparam int OUT_DIM = 128;
    localparam int LANES   = 4;
    localparam int ACC_W   = 24;
    localparam int GROUPS  = OUT_DIM / LANES;
    localparam int WORDS   = GROUPS * IN_DIM;
    localparam int ADDR_W  = $clog2(WORDS);
    localparam int LAT     = GROUPS * (IN_DIM + 2) + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [4:0]           shift = '0;
    logic [8*IN_DIM-1:0]  in_vec = '0;
    logic                 weight_en;
    logic [ADDR_W-1:0]    weight_addr;
    logic [8*LANES-1:0]   weight_data = '0;
    logic [8*OUT_DIM-1:0] out_vec;
    logic                 busy;
    logic                 done;

    logic [8*LANES-1:0]   wmem [WORDS];
    int                   wmat [OUT_DIM][IN_DIM];
    int                   xv [IN_DIM];
    int                   hits [WORDS];
    logic [8*OUT_DIM-1:0] exp_vec;
    int                   n_cmp = 0;
    int                   n_fail = 0;

    always #5 clk = ~clk;

    matvec_int8_lanes #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .shift_i(shift), .in_vec_i(in_vec),
        .weight_en_o(weight_en), .weight_addr_o(weight_addr), .weight_data_i(weight_data),
        .out_vec_o(out_vec), .busy_o(busy), .done_o(done));

    // Synchronous weight BRAM with one-cycle read latency.
    always @(posedge clk) if (weight_en) weight_data <= wmem[weight_addr];

    task automatic fill_weights_const(input int v);
        for (int r = 0; r < OUT_DIM; r++) for (int c = 0; c < IN_DIM; c++) wmat[r][c] = v;
    endtask

    task automatic fill_weights_pattern();
        for (int r = 0; r < OUT_DIM; r++) for (int c = 0; c < IN_DIM; c++) wmat[r][c] = (r + c) % 7 - 3;
    endtask

    task automatic fill_x_const(input int v);
        for (int c = 0; c < IN_DIM; c++) xv[c] = v;
    endtask

    task automatic fill_x_random();
        for (int c = 0; c < IN_DIM; c++) xv[c] = int'($urandom_range(255)) - 128;
    endtask

    // Place matrix and vector into the BRAM image and the input bus.
    task automatic load_all();
        for (int r = 0; r < OUT_DIM; r++)
            for (int c = 0; c < IN_DIM; c++)
                wmem[(r / LANES) * IN_DIM + c][8*(r % LANES) +: 8] = 8'(wmat[r][c]);
        for (int c = 0; c < IN_DIM; c++) in_vec[8*c +: 8] = 8'(xv[c]);
    endtask

    // Reference: exact dot product, floor((sum + 2^(s-1)) / 2^s), clamp to int8.
    task automatic compute_expected(input int sh);
        for (int r = 0; r < OUT_DIM; r++) begin
            longint sum = 0;
            longint d, num, q;
            for (int c = 0; c < IN_DIM; c++) sum += longint'(wmat[r][c]) * longint'(xv[c]);
            if (sh == 0) q = sum;
            else begin
                d   = longint'(1) << sh;
                num = sum + d / 2;
                q   = num / d;
                if ((num % d != 0) && (num < 0)) q = q - 1;
            end
            if (q > 127) q = 127;
            if (q < -128) q = -128;
`ifdef MATVEC_LANES_RELU_EN
            if (q < 0) q = 0;
`endif
            exp_vec[8*r +: 8] = 8'(q);
        end
    endtask

    function automatic int first_diff();
        for (int r = 0; r < OUT_DIM; r++) if (out_vec[8*r +: 8] !== exp_vec[8*r +: 8]) return r;
        return 0;
    endfunction

    // Start a pass (next posedge accepts) and follow it to done_o.
    // Returns at the negedge in which done_o is high.
    task automatic run_pass(input logic [4:0] sh, input int pulse_at, input int change_at,
                            output int done_edge, output int busy_bad, output int addr_bad);
        int k;
        for (int a = 0; a < WORDS; a++) hits[a] = 0;
        done_edge = -1; busy_bad = 0; addr_bad = 0;
        shift = sh; start = 1'b1;
        @(posedge clk);
        k = 1;
        while (k <= LAT + 50) begin
            @(negedge clk);
            start = (k == pulse_at);
            if (k == pulse_at) shift = ~sh;
            if (k == change_at) in_vec = ~in_vec;
            if (weight_en) hits[weight_addr] = hits[weight_addr] + 1;
            if (done) begin
                done_edge = k;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            @(posedge clk);
            k++;
        end
        for (int a = 0; a < WORDS; a++) if (hits[a] != 1) addr_bad++;
        if (done_edge < 0) begin rst = 1'b1; @(negedge clk); rst = 1'b0; end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (out_vec !== '0) begin n_fail++; $display("FAIL reset out_vec: got %h, need 0", out_vec[31:0]); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, need 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b, need 0", done); end
        n_cmp++; if (weight_en !== 1'b0) begin n_fail++; $display("FAIL reset weight_en: got %b, need 0", weight_en); end
        n_cmp++; if (weight_addr !== '0) begin n_fail++; $display("FAIL reset weight_addr: got %0d, need 0", weight_addr); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: checked idle outputs");
    endtask

    task automatic test_all_ones();
        int de, bb, ab;
        fill_weights_const(1); fill_x_const(1); load_all(); compute_expected(0);
        run_pass(5'd0, -1, -1, de, bb, ab);
        n_cmp++; if (de !== LAT) begin n_fail++; $display("FAIL all_ones latency: got edge %0d, need %0d", de, LAT); end
        n_cmp++; if (bb !== 0) begin n_fail++; $display("FAIL all_ones busy: %0d bad cycles, need 0", bb); end
        n_cmp++; if (ab !== 0) begin n_fail++; $display("FAIL all_ones addr sweep: %0d bad addresses, need 0", ab); end
        n_cmp++; if (out_vec !== exp_vec) begin n_fail++;
            $display("FAIL all_ones out row %0d: got %0d, need %0d", first_diff(), $signed(out_vec[8*first_diff() +: 8]), $signed(exp_vec[8*first_diff() +: 8])); end
        $display("all_ones: done at edge %0d", de);
        @(negedge clk);
    endtask

    task automatic test_requant();
        int wv [2] = '{1, -1};
        int sv [2] = '{1, 0};
        int de, bb, ab;
        for (int t = 0; t < 2; t++) begin
            fill_weights_const(wv[t]); fill_x_const(1); load_all(); compute_expected(sv[t]);
            run_pass(5'(sv[t]), -1, -1, de, bb, ab);
            n_cmp++; if (de !== LAT) begin n_fail++; $display("FAIL requant%0d latency: got edge %0d, need %0d", t, de, LAT); end
            n_cmp++; if (out_vec !== exp_vec) begin n_fail++;
                $display("FAIL requant%0d out row %0d: got %0d, need %0d", t, first_diff(), $signed(out_vec[8*first_diff() +: 8]), $signed(exp_vec[8*first_diff() +: 8])); end
            $display("requant%0d: w=%0d shift=%0d row0=%0d", t, wv[t], sv[t], $signed(out_vec[7:0]));
            @(negedge clk);
        end
    endtask

    task automatic test_rounding();
        int de, bb, ab;
        fill_weights_const(0); fill_x_const(1);
        wmat[0][5] = 1;  wmat[0][17] = 1;  wmat[0][100] = 1;
        wmat[1][2] = -1; wmat[1][64] = -1; wmat[1][127] = -1;
        load_all(); compute_expected(1);
        run_pass(5'd1, -1, -1, de, bb, ab);
        n_cmp++; if (out_vec !== exp_vec) begin n_fail++;
            $display("FAIL rounding out row %0d: got %0d, need %0d", first_diff(), $signed(out_vec[8*first_diff() +: 8]), $signed(exp_vec[8*first_diff() +: 8])); end
        $display("rounding: row0=%0d row1=%0d", $signed(out_vec[7:0]), $signed(out_vec[15:8]));
        @(negedge clk);
    endtask

    task automatic test_layout_random();
        int de, bb, ab, sh;
        fill_weights_pattern();
        for (int t = 0; t < 2; t++) begin
            fill_x_random(); sh = int'($urandom_range(8));
            load_all(); compute_expected(sh);
            run_pass(5'(sh), -1, -1, de, bb, ab);
            n_cmp++; if (ab !== 0) begin n_fail++; $display("FAIL layout%0d addr sweep: %0d bad addresses, need 0", t, ab); end
            n_cmp++; if (out_vec !== exp_vec) begin n_fail++;
                $display("FAIL layout%0d out row %0d: got %0d, need %0d", t, first_diff(), $signed(out_vec[8*first_diff() +: 8]), $signed(exp_vec[8*first_diff() +: 8])); end
            $display("layout%0d: shift=%0d done at edge %0d", t, sh, de);
            @(negedge clk);
        end
    endtask

    task automatic test_control();
        int de, bb, ab, sh;
        fill_weights_pattern(); fill_x_random(); sh = int'($urandom_range(8));
        load_all(); compute_expected(sh);
        run_pass(5'(sh), 500, 2, de, bb, ab);
        n_cmp++; if (de !== LAT) begin n_fail++; $display("FAIL control latency: got edge %0d, need %0d", de, LAT); end
        n_cmp++; if (bb !== 0) begin n_fail++; $display("FAIL control busy: %0d bad cycles, need 0", bb); end
        n_cmp++; if (out_vec !== exp_vec) begin n_fail++;
            $display("FAIL control out row %0d: got %0d, need %0d", first_diff(), $signed(out_vec[8*first_diff() +: 8]), $signed(exp_vec[8*first_diff() +: 8])); end
        $display("control: mid-pass start and input change, done at edge %0d", de);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int de, bb, ab, sh;
        fill_weights_pattern(); fill_x_random(); sh = int'($urandom_range(8));
        load_all(); compute_expected(sh);
        run_pass(5'(sh), -1, -1, de, bb, ab);
        n_cmp++; if (out_vec !== exp_vec) begin n_fail++;
            $display("FAIL b2b_first out row %0d: got %0d, need %0d", first_diff(), $signed(out_vec[8*first_diff() +: 8]), $signed(exp_vec[8*first_diff() +: 8])); end
        // Raise start already in the done cycle; it must only take effect from IDLE.
        fill_x_random(); sh = int'($urandom_range(8));
        load_all(); compute_expected(sh);
        shift = 5'(sh); start = 1'b1;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b idle cycle: done=%b busy=%b, need 0 0", done, busy); end
        run_pass(5'(sh), -1, -1, de, bb, ab);
        n_cmp++; if (de !== LAT) begin n_fail++; $display("FAIL b2b latency: got edge %0d, need %0d", de, LAT); end
        n_cmp++; if (out_vec !== exp_vec) begin n_fail++;
            $display("FAIL b2b_second out row %0d: got %0d, need %0d", first_diff(), $signed(out_vec[8*first_diff() +: 8]), $signed(exp_vec[8*first_diff() +: 8])); end
        $display("back_to_back: second pass done at edge %0d", de);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_pass();
        int de, bb, ab, sh, dones;
        fill_weights_pattern(); fill_x_random(); sh = int'($urandom_range(8));
        load_all(); compute_expected(sh);
        shift = 5'(sh); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (999) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (out_vec !== '0) begin n_fail++; $display("FAIL midreset out_vec: got %h, need 0", out_vec[31:0]); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset flags: busy=%b done=%b, need 0 0", busy, done); end
        n_cmp++; if (weight_en !== 1'b0 || weight_addr !== '0) begin n_fail++; $display("FAIL midreset bram: en=%b addr=%0d, need 0 0", weight_en, weight_addr); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (20) begin @(negedge clk); if (done || busy) dones++; end
        n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL midreset aftermath: %0d cycles with done/busy, need 0", dones); end
        run_pass(5'(sh), -1, -1, de, bb, ab);
        n_cmp++; if (de !== LAT) begin n_fail++; $display("FAIL midreset rerun latency: got edge %0d, need %0d", de, LAT); end
        n_cmp++; if (out_vec !== exp_vec) begin n_fail++;
            $display("FAIL midreset rerun out row %0d: got %0d, need %0d", first_diff(), $signed(out_vec[8*first_diff() +: 8]), $signed(exp_vec[8*first_diff() +: 8])); end
        $display("reset_mid_pass: rerun done at edge %0d", de);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_requant();
        test_rounding();
        test_layout_random();
        test_control();
        test_back_to_back();
        test_reset_mid_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
